// File: rtl/mem_pkg.sv
// Shared data-memory access encoding used by the load/store unit and the memory model.
// Holds the access-code enum plus helpers for the access width and the load-result extension.
package mem_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_XFER,
        LSU_DONE
    } lsu_state_t;

    // Number of bytes moved by an access; 0 flags an illegal code.
    function automatic logic [2:0] dm_bytes(dm_ctrl_t ctrl);
        case (ctrl)
            DM_B, DM_BU: return 3'd1;
            DM_H, DM_HU: return 3'd2;
            DM_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] dm_extend(dm_ctrl_t ctrl, logic [31:0] acc);
        case (ctrl)
            DM_B:    return {{24{acc[7]}}, acc[7:0]};
            DM_BU:   return {24'h0, acc[7:0]};
            DM_H:    return {{16{acc[15]}}, acc[15:0]};
            DM_HU:   return {16'h0, acc[15:0]};
            DM_W:    return acc;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-result extension: sign/zero-extends the assembled bytes by access code.
module lsu_extend
    import mem_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [31:0] acc,
    output logic [31:0] data
);

    assign data = dm_extend(dm_ctrl_t'(ctrl), acc);

endmodule

// File: rtl/lsu_byte_master.sv
// MEM-stage load/store initiator: serialises each access big-endian, one byte per cycle,
// onto a byte-wide memory port and returns an extended load result.
module lsu_byte_master
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_ctrl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        n_q, n_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       acc_q, acc_d;

    logic [31:0]       ext_data;
    logic [1:0]        byte_idx;
    logic [31:0]       wdata_shift;
    logic              in_xfer;
    logic              in_done;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
        state_d = state_q;
        we_d    = we_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        n_d     = n_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    ctrl_d  = req_ctrl;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    n_d     = dm_bytes(dm_ctrl_t'(req_ctrl));
                    k_d     = 2'd0;
                    acc_d   = 32'h0;
                    state_d = (n_d != 3'd0) ? LSU_XFER : LSU_DONE;
                end
            end
            LSU_XFER: begin
                if (!we_q) begin
                    acc_d = {acc_q[23:0], mem_rdata};
                end
                if ({1'b0, k_q} == n_q - 3'd1) begin
                    state_d = LSU_DONE;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; async reset clears everything so strobes drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            ctrl_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            n_q     <= 3'd0;
            k_q     <= 2'd0;
            acc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    lsu_extend u_extend (
        .ctrl (ctrl_q),
        .acc  (acc_q),
        .data (ext_data)
    );

    // Big-endian: byte k of an N-byte access is wdata byte N-1-k.
    assign byte_idx    = 2'(n_q - 3'd1 - {1'b0, k_q});
    assign wdata_shift = wdata_q >> {byte_idx, 3'b000};
    assign in_xfer     = (state_q == LSU_XFER);
    assign in_done     = (state_q == LSU_DONE);

    always_comb begin
        req_ready = (state_q == LSU_IDLE);
        busy      = !req_ready;
        mem_we    = in_xfer && we_q;
        mem_re    = in_xfer && !we_q;
        mem_addr  = in_xfer ? addr_q + ADDR_W'(k_q) : '0;
        mem_wdata = mem_we ? wdata_shift[7:0] : 8'h00;
        rsp_valid = in_done;
        rsp_err   = in_done && (n_q == 3'd0);
        rsp_rdata = (in_done && !we_q && n_q != 3'd0) ? ext_data : 32'h0;
    end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed bench for lsu_byte_master with a small byte-wide data-memory model.
module tb_lsu_byte_master;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_ctrl = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'h0;
    logic [7:0]  pl_data = 8'h00;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lsu_byte_master #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_ctrl  (req_ctrl),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: 4 KiB aliased on the low address bits, plus a backdoor preload port.
    assign mem_rdata = mem_re ? mem[mem_addr[11:0]] : 8'h00;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
        if (pl_en)  mem[pl_addr] <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Called at a negedge; waits (bounded) for req_ready, then presents the request for one edge.
    task automatic issue(input string tag, input logic we, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) check({tag, " ready timeout"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Full transaction: exp_bytes holds the bytes for cycles 1..n from bit 31 downward.
    task automatic txn(input string tag, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata, input int n,
                       input logic [31:0] exp_bytes, input logic [31:0] exp_rdata,
                       input logic exp_err);
        issue(tag, we, ctrl, addr, wdata);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d mem_we", tag, c), 32'(mem_we), 32'(we));
            check($sformatf("%s c%0d mem_re", tag, c), 32'(mem_re), 32'(!we));
            check($sformatf("%s c%0d mem_addr", tag, c), mem_addr, addr + 32'(c - 1));
            check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'd1);
            check($sformatf("%s c%0d rsp_valid", tag, c), 32'(rsp_valid), 32'd0);
            if (we) check($sformatf("%s c%0d wdata", tag, c), 32'(mem_wdata),
                          32'(exp_bytes[31 - 8*(c-1) -: 8]));
        end
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " done strobes"}, {30'h0, mem_we, mem_re}, 32'h0);
        check({tag, " done mem_addr"}, mem_addr, 32'h0);
        check({tag, " done ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, " ready back"}, 32'(req_ready), 32'd1);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #12;
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset strobes", {30'h0, mem_we, mem_re}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", 32'(mem_wdata), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        preload(12'h042, 8'hAA);
        preload(12'h043, 8'h55);
        preload(12'hFFF, 8'hA1);
        preload(12'h000, 8'hB2);
        preload(12'h001, 8'hC3);
        preload(12'h002, 8'hD4);
        @(negedge clk);

        txn("st_w", 1'b1, DM_W, 32'h10, 32'hDEADBEEF, 4, 32'hDEADBEEF, 32'h0, 1'b0);
        check("mem 0x10", 32'(mem[12'h010]), 32'hDE);
        check("mem 0x11", 32'(mem[12'h011]), 32'hAD);
        check("mem 0x12", 32'(mem[12'h012]), 32'hBE);
        check("mem 0x13", 32'(mem[12'h013]), 32'hEF);

        txn("ld_b",  1'b0, DM_B,  32'h13, 32'h0, 1, 32'h0, 32'hFFFFFFEF, 1'b0);
        txn("ld_bu", 1'b0, DM_BU, 32'h13, 32'h0, 1, 32'h0, 32'h000000EF, 1'b0);
        txn("ld_h",  1'b0, DM_H,  32'h11, 32'h0, 2, 32'h0, 32'hFFFFADBE, 1'b0);
        txn("ld_hu", 1'b0, DM_HU, 32'h11, 32'h0, 2, 32'h0, 32'h0000ADBE, 1'b0);
        txn("ld_w",  1'b0, DM_W,  32'h10, 32'h0, 4, 32'h0, 32'hDEADBEEF, 1'b0);

        txn("st_h", 1'b1, DM_H, 32'h3FF, 32'h00001234, 2, 32'h12340000, 32'h0, 1'b0);
        check("mem 0x3FF", 32'(mem[12'h3FF]), 32'h12);
        check("mem 0x400", 32'(mem[12'h400]), 32'h34);

        txn("illegal", 1'b0, 3'b011, 32'h20, 32'h0, 0, 32'h0, 32'h0, 1'b1);

        issue("rst", 1'b1, DM_W, 32'h40, 32'h11223344);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst c3 mem_we before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst mem_we drop", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 check("rst hold rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mem 0x40", 32'(mem[12'h040]), 32'h11);
        check("mem 0x41", 32'(mem[12'h041]), 32'h22);
        check("mem 0x42", 32'(mem[12'h042]), 32'hAA);
        check("mem 0x43", 32'(mem[12'h043]), 32'h55);

        // Issued right after release: the very first edge must accept it.
        txn("ld_wrap", 1'b0, DM_W, 32'hFFFFFFFF, 32'h0, 4, 32'h0, 32'hA1B2C3D4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
